// File: rtl/aibcr3_dbuf_pkg.sv
// Shared definitions for the aibcr3 data-buffer enable sequencer: state encoding,
// the state type and a width helper.
package aibcr3_dbuf_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t OFF     = 2'd0;
    localparam seq_state_t RAMP_UP = 2'd1;
    localparam seq_state_t ON      = 2'd2;
    localparam seq_state_t RAMP_DN = 2'd3;

    // Ceiling log2, floored at 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/aibcr3_dbuf_step_cnt.sv
// Dwell counter for one lane step: counts enabled cycles, flags the last dwell cycle
// and the first (zero) cycle of a lane.
module aibcr3_dbuf_step_cnt
    import aibcr3_dbuf_pkg::*;
#(
    parameter int STEP_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o,
    output logic zero_o
);

    localparam int CNT_W = clog2(STEP_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over count so a lane hand-off always restarts the dwell at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(STEP_CYC - 1));
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aibcr3_dbuf_en_seq.sv
// Staggered per-lane data-buffer enable sequencer: ramps lanes on in ascending order
// and off in descending order with a fixed dwell per lane, skipping masked lanes.
module aibcr3_dbuf_en_seq
    import aibcr3_dbuf_pkg::*;
#(
    parameter int NUM_LANE = 24,
    parameter int STEP_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_req,
    input  logic [NUM_LANE-1:0] lane_mask,
    output logic [NUM_LANE-1:0] buf_en,
    output logic                en_ack,
    output logic                busy,
    output seq_state_t          dbg_state_o
);

    localparam int IDX_W = clog2(NUM_LANE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANE - 1);

    // 4-phase handshake: en_req rises, en_ack rises once every unmasked lane is on;
    // en_req falls, en_ack drops as the descending ramp starts and stays low until ON again.
    seq_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_LANE-1:0] buf_en_q, buf_en_d;
    logic                en_ack_q, busy_q;
    logic                cnt_clr, cnt_en, step_done, cnt_zero;
    logic                lane_skip, lane_done;

    aibcr3_dbuf_step_cnt #(
        .STEP_CYC (STEP_CYC)
    ) u_step_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .done_o (step_done),
        .zero_o (cnt_zero)
    );

    // A lane is only judged skippable on its first cycle, so clearing/setting its own
    // enable bit mid-dwell cannot cut the dwell short.
    always_comb begin
        lane_skip = 1'b0;
        if (state_q == RAMP_UP) begin
            lane_skip = lane_mask[idx_q];
        end else if (state_q == RAMP_DN) begin
            lane_skip = ~buf_en_q[idx_q];
        end
    end

    assign lane_done = step_done | (cnt_zero & lane_skip);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buf_en_d = buf_en_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            OFF: begin
                if (en_req) begin
                    state_d = RAMP_UP;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            RAMP_UP: begin
                if (!en_req) begin
                    state_d = RAMP_DN;
                    cnt_clr = 1'b1;
                end else begin
                    if (cnt_zero && !lane_skip) begin
                        buf_en_d[idx_q] = 1'b1;
                    end
                    if (lane_done) begin
                        cnt_clr = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ON;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ON: begin
                if (!en_req) begin
                    state_d = RAMP_DN;
                    idx_d   = LAST_IDX;
                    cnt_clr = 1'b1;
                end
            end
            RAMP_DN: begin
                if (en_req) begin
                    state_d = RAMP_UP;
                    cnt_clr = 1'b1;
                end else begin
                    if (cnt_zero && !lane_skip) begin
                        buf_en_d[idx_q] = 1'b0;
                    end
                    if (lane_done) begin
                        cnt_clr = 1'b1;
                        if (idx_q == '0) begin
                            state_d = OFF;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d = OFF;
                idx_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
        // Masked lanes are forced off in every state, one cycle after the mask changes.
        buf_en_d = buf_en_d & ~lane_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OFF;
            idx_q    <= '0;
            buf_en_q <= '0;
            en_ack_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_en_q <= buf_en_d;
            en_ack_q <= (state_d == ON);
            busy_q   <= (state_d == RAMP_UP) || (state_d == RAMP_DN);
        end
    end

    assign buf_en      = buf_en_q;
    assign en_ack      = en_ack_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aibcr3_dbuf_en_seq.sv
// Directed bench for aibcr3_dbuf_en_seq (4 lanes, 3-cycle dwell): expected per-cycle
// {buf_en, en_ack, busy} words are queued with the stimulus and popped as cycles elapse.
module tb_aibcr3_dbuf_en_seq;
    import aibcr3_dbuf_pkg::*;

    localparam int NL = 4;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_req;
    logic [NL-1:0] lane_mask;
    logic [NL-1:0] buf_en;
    logic          en_ack;
    logic          busy;
    seq_state_t    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [NL+1:0] exp_q[$];

    always #5 clk = ~clk;

    aibcr3_dbuf_en_seq #(
        .NUM_LANE (NL),
        .STEP_CYC (SC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_req      (en_req),
        .lane_mask   (lane_mask),
        .buf_en      (buf_en),
        .en_ack      (en_ack),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [NL+1:0] mk(input logic [NL-1:0] be, input logic ack, input logic bsy);
        return {be, ack, bsy};
    endfunction

    // Full ascending ramp with nothing masked, cycle c counted from the request edge.
    function automatic logic [NL+1:0] up_word(input int c);
        logic [NL-1:0] be;
        be = '0;
        for (int i = 0; i < NL; i++) begin
            if (c >= 2 + SC * i) be[i] = 1'b1;
        end
        return mk(be, c >= 1 + NL * SC, (c >= 1) && (c <= NL * SC));
    endfunction

    // Full descending ramp starting with every lane on.
    function automatic logic [NL+1:0] dn_word(input int c);
        logic [NL-1:0] be;
        be = '0;
        for (int i = 0; i < NL; i++) begin
            if (c < 2 + SC * (NL - 1 - i)) be[i] = 1'b1;
        end
        return mk(be, 1'b0, (c >= 1) && (c <= NL * SC));
    endfunction

    task automatic drain(input string tag, input int c0, input int n);
        logic [NL+1:0] exp;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_val($sformatf("%s_empty_c%0d", tag, c0 + k), 8'd1, 8'd0);
            end else begin
                exp = exp_q.pop_front();
                check_val($sformatf("%s_c%0d", tag, c0 + k), 8'({buf_en, en_ack, busy}), 8'(exp));
            end
            check_val($sformatf("%s_maskinv_c%0d", tag, c0 + k), 8'(buf_en & lane_mask), 8'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en_req    = 1'b0;
        lane_mask = '0;
        repeat (2) @(negedge clk);
        check_val("reset_out", 8'({buf_en, en_ack, busy}), 8'd0);
        check_val("reset_state", 8'(dbg_state), 8'(OFF));
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) exp_q.push_back(mk('0, 1'b0, 1'b0));
        drain("idle", 0, 2);

        // Full ramp up, nothing masked.
        for (int c = 1; c <= 14; c++) exp_q.push_back(up_word(c));
        en_req = 1'b1;
        drain("up", 1, 14);
        check_val("up_state", 8'(dbg_state), 8'(ON));

        // Full ramp down from ON.
        for (int c = 1; c <= 14; c++) exp_q.push_back(dn_word(c));
        en_req = 1'b0;
        drain("dn", 1, 14);
        check_val("dn_state", 8'(dbg_state), 8'(OFF));

        // Lanes 0 and 2 masked: ramp up then down.
        lane_mask = 4'b0101;
        for (int c = 1; c <= 10; c++) begin
            exp_q.push_back(mk((c >= 7) ? 4'b1010 : (c >= 3) ? 4'b0010 : 4'b0000,
                               c >= 9, (c >= 1) && (c <= 8)));
        end
        en_req = 1'b1;
        drain("mask_up", 1, 10);
        for (int c = 1; c <= 10; c++) begin
            exp_q.push_back(mk((c < 2) ? 4'b1010 : (c < 6) ? 4'b0010 : 4'b0000,
                               1'b0, (c >= 1) && (c <= 8)));
        end
        en_req = 1'b0;
        drain("mask_dn", 1, 10);
        lane_mask = '0;

        // Reversal while lane 1 dwells.
        for (int c = 1; c <= 5; c++) exp_q.push_back(up_word(c));
        en_req = 1'b1;
        drain("rev_up", 1, 5);
        for (int c = 6; c <= 13; c++) begin
            exp_q.push_back(mk((c == 6) ? 4'b0011 : (c <= 9) ? 4'b0001 : 4'b0000,
                               1'b0, c <= 11));
        end
        en_req = 1'b0;
        drain("rev_dn", 6, 8);
        check_val("rev_state", 8'(dbg_state), 8'(OFF));

        // Asynchronous reset mid ramp, then a clean restart.
        for (int c = 1; c <= 8; c++) exp_q.push_back(up_word(c));
        en_req = 1'b1;
        drain("pre_rst", 1, 8);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_out", 8'({buf_en, en_ack, busy}), 8'd0);
        check_val("async_rst_state", 8'(dbg_state), 8'(OFF));
        @(negedge clk);
        check_val("rst_hold_out", 8'({buf_en, en_ack, busy}), 8'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 14; c++) exp_q.push_back(up_word(c));
        drain("restart", 1, 14);

        // Masking a lane while ON, then unmasking it.
        lane_mask = 4'b0100;
        for (int c = 1; c <= 3; c++) exp_q.push_back(mk(4'b1011, 1'b1, 1'b0));
        drain("on_mask", 1, 3);
        lane_mask = '0;
        for (int c = 1; c <= 3; c++) exp_q.push_back(mk(4'b1011, 1'b1, 1'b0));
        drain("on_unmask", 1, 3);

        // Ramp down with lane 2 already off.
        for (int c = 1; c <= 12; c++) begin
            exp_q.push_back(mk((c < 2) ? 4'b1011 : (c < 6) ? 4'b0011 : (c < 9) ? 4'b0001 : 4'b0000,
                               1'b0, c <= 10));
        end
        en_req = 1'b0;
        drain("hole_dn", 1, 12);

        // Every lane masked: one cycle per lane, ack with nothing enabled.
        lane_mask = 4'b1111;
        for (int c = 1; c <= 6; c++) exp_q.push_back(mk(4'b0000, c >= 5, c <= 4));
        en_req = 1'b1;
        drain("all_mask", 1, 6);

        check_val("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
